// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operand width, op encodings, FSM states.
package mdu_pkg;

    localparam int WIDTH = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mdu_div_iter.sv
// Restoring divider datapath: one quotient bit per step on unsigned operands.
// Latency: one step per enabled cycle, 32 steps per divide; no backpressure, load/step driven by the owner FSM.
module mdu_div_iter
    import mdu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    logic [WIDTH-1:0] dvsr;
    logic [WIDTH:0]   shifted;
    logic             ge;

    // Partial remainder is always below the divisor, so the shifted value fits in 33 bits
    // and a successful subtract always leaves a result that fits in 32.
    assign shifted = {rem, quo[WIDTH-1]};
    assign ge      = (shifted >= {1'b0, dvsr});

    always_ff @(posedge clk) begin
        if (rst) begin
            quo  <= '0;
            rem  <= '0;
            dvsr <= '0;
        end else if (load) begin
            quo  <= dividend;
            rem  <= '0;
            dvsr <= divisor;
        end else if (step) begin
            quo <= {quo[WIDTH-2:0], ge};
            rem <= ge ? (shifted[WIDTH-1:0] - dvsr) : shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit; divide support only when MDU_DIV_EN is defined.
// Latency: result written in the 33rd cycle after start; start is ignored while busy (no queuing).
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             hi_wena,
    output logic             lo_wena,
    output logic [WIDTH-1:0] hi_wdata,
    output logic [WIDTH-1:0] lo_wdata
);
    import mdu_pkg::*;

    state_t             state, state_nxt;
    logic [4:0]         cnt;
    logic               div_q;
    logic               neg_q;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH:0]     sum;
    logic               op_div, op_signed, accept, wr;
    logic [WIDTH-1:0]   abs_a, abs_b;

    assign op_div    = (op == OP_DIVU) || (op == OP_DIV);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign accept    = (state == S_IDLE) && start;
    assign abs_a     = (op_signed && a[WIDTH-1]) ? -a : a;
    assign abs_b     = (op_signed && b[WIDTH-1]) ? -b : b;

    // Shift-add step: add the multiplicand into the upper half when the low bit is set, then shift right.
    assign sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef MDU_DIV_EN
                    state_nxt = S_CALC;
`else
                    state_nxt = op_div ? S_DONE : S_CALC;
`endif
                end
            end
            S_CALC:  if (cnt == 5'd31) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            div_q <= 1'b0;
            neg_q <= 1'b0;
            mcand <= '0;
            prod  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt   <= '0;
                div_q <= op_div;
                neg_q <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                mcand <= abs_a;
                prod  <= {{WIDTH{1'b0}}, abs_b};
            end else if (state == S_CALC) begin
                cnt <= cnt + 5'd1;
                if (!div_q) prod <= {sum, prod[WIDTH-1:1]};
            end
        end
    end

`ifdef MDU_DIV_EN
    logic [WIDTH-1:0] quo, rem, a_q;
    logic             b_zero, neg_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_zero <= 1'b0;
            neg_r  <= 1'b0;
        end else if (accept) begin
            a_q    <= a;
            b_zero <= (b == '0);
            neg_r  <= op_signed & a[WIDTH-1];
        end
    end

    mdu_div_iter u_div_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && op_div),
        .step     ((state == S_CALC) && div_q),
        .dividend (abs_a),
        .divisor  (abs_b),
        .quo      (quo),
        .rem      (rem)
    );

    assign wr = (state == S_DONE);
`else
    assign wr = (state == S_DONE) && !div_q;
`endif

    always_comb begin
        hi_wdata = '0;
        lo_wdata = '0;
        prod_s   = neg_q ? -prod : prod;
        if (wr) begin
            if (!div_q) begin
                hi_wdata = prod_s[2*WIDTH-1:WIDTH];
                lo_wdata = prod_s[WIDTH-1:0];
            end
`ifdef MDU_DIV_EN
            else if (b_zero) begin
                hi_wdata = a_q;
                lo_wdata = '1;
            end else begin
                lo_wdata = neg_q ? -quo : quo;
                hi_wdata = neg_r ? -rem : rem;
            end
`endif
        end
    end

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign hi_wena = wr;
    assign lo_wena = wr;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table plus timing sequences, scoreboarded HI/LO writes.
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int LOOPN = 70;

    logic        clk, rst, start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, hi_wena, lo_wena;
    logic [31:0] hi_wdata, lo_wdata;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi_wena(hi_wena), .lo_wena(lo_wena),
        .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
    );

    typedef struct { string nm; logic [1:0] op; logic [31:0] a, b, hi, lo; } vec_t;
    typedef struct { string nm; logic [31:0] hi, lo; } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   idle_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] p;
        logic [31:0] q, r;
        if (o == OP_MULTU) return {32'h0, x} * {32'h0, y};
        if (o == OP_MULT) begin
            p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
            return p;
        end
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        if (o == OP_DIVU) return {x % y, x / y};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
    endfunction

    // Scoreboard: every write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!hi_wena && hi_wdata != 32'h0) idle_bad++;
        if (!lo_wena && lo_wdata != 32'h0) idle_bad++;
        if (hi_wena || lo_wena) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got hi=%h lo=%h, expected no write", hi_wdata, lo_wdata);
            end else begin
                mon_e = sbq.pop_front();
                check({mon_e.nm, "_hi"}, {32'h0, hi_wdata}, {32'h0, mon_e.hi});
                check({mon_e.nm, "_lo"}, {32'h0, lo_wdata}, {32'h0, mon_e.lo});
            end
        end
    end

    // Issue one op at cycle N, optionally inject a second start and/or reset at cycle offsets,
    // then watch LOOPN cycles and check done timing, pulse count and busy count.
    task automatic run(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit push_first, input logic [31:0] ehi, input logic [31:0] elo,
                       input int inj_at, input logic [1:0] io, input logic [31:0] ix, input logic [31:0] iy,
                       input bit inj_push, input int rst_at,
                       input int exp_done_at, input int exp_dones, input int exp_busy, input bit exp_wena);
        int   done_at, n_done, n_busy;
        exp_t e;
        logic [63:0] r;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        if (push_first) begin
            e.nm = nm; e.hi = ehi; e.lo = elo;
            sbq.push_back(e);
        end
        done_at = -1; n_done = 0; n_busy = 0;
        for (int k = 1; k <= LOOPN; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            rst   = 1'b0;
            if (k == inj_at) begin
                start = 1'b1; op = io; a = ix; b = iy;
                if (inj_push) begin
                    r = model(io, ix, iy);
                    e.nm = {nm, "_second"}; e.hi = r[63:32]; e.lo = r[31:0];
                    sbq.push_back(e);
                end
            end
            if (k == rst_at) rst = 1'b1;
            @(negedge clk);
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
            if (k == exp_done_at) check({nm, "_wena"}, {62'h0, hi_wena, lo_wena}, {62'h0, exp_wena, exp_wena});
        end
        check({nm, "_done_cycle"}, done_at, exp_done_at);
        check({nm, "_done_count"}, n_done, exp_dones);
        check({nm, "_busy_cycles"}, n_busy, exp_busy);
    endtask

    initial begin
        vec_t        tbl[$];
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        logic [63:0] rr;

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;

        tbl.push_back('{"multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
        tbl.push_back('{"mult_neg3x5", OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1});
        tbl.push_back('{"multu_7x9",   OP_MULTU, 32'h00000007, 32'h00000009, 32'h00000000, 32'h0000003F});
        tbl.push_back('{"mult_minsq",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
        tbl.push_back('{"mult_m1xm1",  OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});
        tbl.push_back('{"multu_zero",  OP_MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000});
        tbl.push_back('{"multu_3x4",   OP_MULTU, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C});
`ifdef MDU_DIV_EN
        tbl.push_back('{"div_neg7_2",  OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
        tbl.push_back('{"divu_5_0",    OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF});
        tbl.push_back('{"div_ovf",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
        tbl.push_back('{"divu_100_7",  OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E});
        tbl.push_back('{"div_7_neg2",  OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
        tbl.push_back('{"div_neg5_0",  OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF});
        tbl.push_back('{"divu_max_1",  OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF});
`endif

        repeat (2) @(negedge clk);
        check("reset_busy",     {63'h0, busy},    64'h0);
        check("reset_done",     {63'h0, done},    64'h0);
        check("reset_hi_wena",  {63'h0, hi_wena}, 64'h0);
        check("reset_lo_wena",  {63'h0, lo_wena}, 64'h0);
        check("reset_hi_wdata", {32'h0, hi_wdata}, 64'h0);
        check("reset_lo_wdata", {32'h0, lo_wdata}, 64'h0);

        // Reset must win over a start on the same edge.
        start = 1'b1; op = OP_MULTU; a = 32'd7; b = 32'd9;
        @(negedge clk);
        check("rst_prio_busy", {63'h0, busy}, 64'h0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_prio_idle", {63'h0, busy}, 64'h0);

        foreach (tbl[i])
            run(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, tbl[i].hi, tbl[i].lo,
                0, 2'b00, 32'h0, 32'h0, 1'b0, 0, 33, 1, 33, 1'b1);

        for (int i = 0; i < 8; i++) begin
`ifdef MDU_DIV_EN
            ro = 2'($urandom_range(0, 3));
`else
            ro = 2'($urandom_range(0, 1));
`endif
            rx = $urandom;
            ry = (i % 2 == 1) ? 32'($urandom_range(0, 20)) : $urandom;
            rr = model(ro, rx, ry);
            run($sformatf("rand%0d", i), ro, rx, ry, 1'b1, rr[63:32], rr[31:0],
                0, 2'b00, 32'h0, 32'h0, 1'b0, 0, 33, 1, 33, 1'b1);
        end

        run("second_start_lost", OP_MULTU, 32'h10, 32'h20, 1'b1, 32'h0, 32'h200,
            5, OP_MULTU, 32'd3, 32'd3, 1'b0, 0, 33, 1, 33, 1'b1);
        run("rst_mid_calc", OP_MULTU, 32'd7, 32'd9, 1'b0, 32'h0, 32'h0,
            12, OP_MULTU, 32'd7, 32'd9, 1'b1, 10, 45, 1, 43, 1'b1);
        run("back_to_back", OP_MULTU, 32'd2, 32'd3, 1'b1, 32'h0, 32'd6,
            34, OP_MULT, 32'hFFFFFFFF, 32'd2, 1'b1, 0, 33, 2, 66, 1'b1);
        run("rst_last_calc", OP_MULTU, 32'd5, 32'd5, 1'b0, 32'h0, 32'h0,
            0, 2'b00, 32'h0, 32'h0, 1'b0, 32, -1, 0, 32, 1'b0);
`ifndef MDU_DIV_EN
        run("nodiv_divu", OP_DIVU, 32'd100, 32'd7, 1'b0, 32'h0, 32'h0,
            0, 2'b00, 32'h0, 32'h0, 1'b0, 0, 1, 1, 1, 1'b0);
        run("nodiv_div", OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 32'h0, 32'h0,
            0, 2'b00, 32'h0, 32'h0, 1'b0, 0, 1, 1, 1, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sbq.size()), 64'h0);
        check("wdata_zero_when_idle", 64'(idle_bad), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port a  input  32  multiplicand or dividend.
REQ-007 SHALL have port b  input  32  multiplier or divisor.
REQ-008 SHALL have port busy  output  1  high while an operation is in flight, including the DONE cycle.
REQ-009 SHALL have port done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port hi_wena  output  1  HI register write enable.
REQ-011 SHALL have port lo_wena  output  1  LO register write enable.
REQ-012 SHALL have port hi_wdata  output  32  HI write data.
REQ-013 SHALL have port lo_wdata  output  32  LO write data.

Function
REQ-014 SHALL implement the FSM IDLE -> CALC -> DONE -> IDLE.
REQ-015 SHALL latch op, a and b on the edge where start=1 in IDLE (cycle N), then enter CALC.
REQ-016 SHALL stay in CALC for exactly 32 cycles (N+1..N+32), with a 5-bit counter running 0..31.
REQ-017 SHALL assert busy in cycles N+1..N+33 only.
REQ-018 SHALL be in DONE in cycle N+33, with done=hi_wena=lo_wena=1 and valid wdata in that cycle only.
REQ-019 SHALL return to IDLE at N+34, so the earliest next start is accepted in cycle N+34.
REQ-020 SHALL ignore start while busy, leaving state and latched operands unchanged.
REQ-021 SHALL compute MULT/MULTU as a 64-bit shift-add product: hi=product[63:32], lo=product[31:0].
REQ-022 SHALL compute DIV/DIVU as a restoring quotient/remainder: lo=quotient, hi=remainder.
REQ-023 SHALL, for signed ops, iterate on absolute values and then fix signs in DONE:
- product sign = sign(a) XOR sign(b)
- quotient sign = sign(a) XOR sign(b)
- remainder sign = sign(a)
REQ-024 SHALL return lo=0x80000000, hi=0 for signed 0x80000000 / 0xFFFFFFFF.
REQ-025 SHALL return hi=a, lo=0xFFFFFFFF for divide by zero (b=0), signed or unsigned, still taking the full 33-cycle latency.
REQ-026 SHALL hold hi_wdata/lo_wdata at 0 whenever hi_wena/lo_wena are low.

Reset
REQ-027 SHALL, when rst=1 on any edge, force IDLE and clear the counter, latched operands and accumulators.
REQ-028 SHALL drive busy=done=hi_wena=lo_wena=0 and both wdata outputs to 0 from the cycle after a reset edge.
REQ-029 SHALL, on reset mid-CALC or mid-DONE, abort the operation with no write issued afterward.
REQ-030 SHALL give rst priority over a simultaneous start.

Configuration
REQ-031 SHALL, with macro MDU_DIV_EN defined, support all four ops as specified above.
REQ-032 SHALL, without MDU_DIV_EN, handle DIV/DIVU as follows:
- skip CALC and go IDLE -> DONE
- done=1 in cycle N+1 with hi_wena=lo_wena=0
- no divider logic synthesized
- MULT/MULTU unchanged

Structure
REQ-033 SHALL place in shared package mdu_pkg:
- op encoding constants (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV)
- FSM state typedef
- WIDTH constant
REQ-034 SHALL place the divider iteration datapath in sub-module mdu_div_iter, instantiated only under MDU_DIV_EN; the multiplier datapath, sign handling and FSM stay in mul_div_unit.

Verification
REQ-035 SHALL cover MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> cycle N+33: done=1, hi=0xFFFFFFFE, lo=0x00000001; busy=1 over N+1..N+33.
REQ-036 SHALL cover MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-037 SHALL cover DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and DIVU a=5 b=0 -> hi=5, lo=0xFFFFFFFF.
REQ-038 SHALL cover start at N, second start at N+5 with different operands -> only the first result written at N+33; the second start is lost.
REQ-039 SHALL cover rst pulse at N+10 of MULTU 7*9 -> busy=0 from N+11; no done or wena through N+40; a new start at N+12 completes normally at N+45.
REQ-040 SHALL cover a build without MDU_DIV_EN: DIVU start at N -> done=1 at N+1 with hi_wena=lo_wena=0; MULTU 3*4 -> lo=12 at N+33.
